// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU opcodes and divider FSM encodings for the RV32 execute stage.
// The M-extension opcodes are always defined here; whether they are implemented
// depends on RV32M_EN in ex_stage.
package ex_stage_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic              RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord  = '0;

  // Base-ISA ALU opcodes
  localparam logic [5:0] EXE_NOP_OP    = 6'h00;
  localparam logic [5:0] EXE_ADD_OP    = 6'h01;
  localparam logic [5:0] EXE_SUB_OP    = 6'h02;
  localparam logic [5:0] EXE_AND_OP    = 6'h03;
  localparam logic [5:0] EXE_OR_OP     = 6'h04;
  localparam logic [5:0] EXE_XOR_OP    = 6'h05;
  localparam logic [5:0] EXE_SLL_OP    = 6'h06;
  localparam logic [5:0] EXE_SRL_OP    = 6'h07;
  localparam logic [5:0] EXE_SRA_OP    = 6'h08;
  localparam logic [5:0] EXE_SLT_OP    = 6'h09;
  localparam logic [5:0] EXE_SLTU_OP   = 6'h0A;
  localparam logic [5:0] EXE_LUI_OP    = 6'h0B;
  localparam logic [5:0] EXE_AUIPC_OP  = 6'h0C;
  localparam logic [5:0] EXE_JAL_OP    = 6'h0D;
  localparam logic [5:0] EXE_JALR_OP   = 6'h0E;

  // M-extension opcodes
  localparam logic [5:0] EXE_MUL_OP    = 6'h10;
  localparam logic [5:0] EXE_MULH_OP   = 6'h11;
  localparam logic [5:0] EXE_MULHSU_OP = 6'h12;
  localparam logic [5:0] EXE_MULHU_OP  = 6'h13;
  localparam logic [5:0] EXE_DIV_OP    = 6'h14;
  localparam logic [5:0] EXE_DIVU_OP   = 6'h15;
  localparam logic [5:0] EXE_REM_OP    = 6'h16;
  localparam logic [5:0] EXE_REMU_OP   = 6'h17;

  // Divider FSM states
  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;
endpackage

// File: rtl/ex_stage_div.sv
// Iterative 32-step restoring divider for DIV/DIVU/REM/REMU.
// Only built when RV32M_EN is defined; otherwise the module does not exist.
// Divide-by-zero and signed overflow are answered combinationally without
// entering BUSY. The caller must hold the operands stable while busy is high.
`ifdef RV32M_EN
module ex_div
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic              annul,
  input  logic [RegBus-1:0] dividend,
  input  logic [RegBus-1:0] divisor,
  output logic              busy,
  output logic              ready,
  output logic [RegBus-1:0] quotient,
  output logic [RegBus-1:0] remainder
);
  logic [1:0]        state_p0;
  logic [4:0]        cnt_p0;
  logic [RegBus-1:0] rem_p0;
  logic [RegBus-1:0] quo_p0;
  logic [RegBus-1:0] dvs_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;

  logic              neg_a;
  logic              neg_b;
  logic [RegBus-1:0] abs_a;
  logic [RegBus-1:0] abs_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic              go;
  logic [RegBus:0]   trial;
  logic              fits;
  logic [RegBus-1:0] diff;

  assign neg_a    = is_signed & dividend[RegBus-1];
  assign neg_b    = is_signed & divisor[RegBus-1];
  assign abs_a    = neg_a ? (ZeroWord - dividend) : dividend;
  assign abs_b    = neg_b ? (ZeroWord - divisor) : divisor;
  assign div_zero = (divisor == ZeroWord);
  assign div_ovf  = is_signed && (dividend == {1'b1, {(RegBus-1){1'b0}}}) && (divisor == '1);
  assign special  = div_zero | div_ovf;
  assign go       = start & ~annul;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The partial remainder can reach
  // 33 bits after the shift, so the compare is one bit wider.
  assign trial = {rem_p0, quo_p0[RegBus-1]};
  assign fits  = (trial >= {1'b0, dvs_p0});
  assign diff  = trial[RegBus-1:0] - dvs_p0;

  // Stall and result handshakes seen by the execute stage
  always_comb begin
    busy      = 1'b0;
    ready     = 1'b0;
    quotient  = ZeroWord;
    remainder = ZeroWord;
    if (rst != RstEnable) begin
      busy  = ((state_p0 == DIV_IDLE) && go && !special) ||
              ((state_p0 == DIV_BUSY) && !annul);
      ready = !annul && (((state_p0 == DIV_IDLE) && go && special) ||
                         (state_p0 == DIV_DONE));
    end
    if (state_p0 == DIV_DONE) begin
      quotient  = neg_q_p0 ? (ZeroWord - quo_p0) : quo_p0;
      remainder = neg_r_p0 ? (ZeroWord - rem_p0) : rem_p0;
    end else if (div_zero) begin
      quotient  = '1;
      remainder = dividend;
    end else begin
      quotient  = {1'b1, {(RegBus-1){1'b0}}};
      remainder = ZeroWord;
    end
  end

  // Divider FSM, iteration counter and working registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_p0 <= DIV_IDLE;
      cnt_p0   <= '0;
      rem_p0   <= ZeroWord;
      quo_p0   <= ZeroWord;
      dvs_p0   <= ZeroWord;
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
    end else begin
      case (state_p0)
        DIV_IDLE: begin
          if (go && !special) begin
            state_p0 <= DIV_BUSY;
            cnt_p0   <= '0;
            rem_p0   <= ZeroWord;
            quo_p0   <= abs_a;
            dvs_p0   <= abs_b;
            neg_q_p0 <= neg_a ^ neg_b;
            neg_r_p0 <= neg_a;
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            state_p0 <= DIV_IDLE;
          end else begin
            rem_p0 <= fits ? diff : trial[RegBus-1:0];
            quo_p0 <= {quo_p0[RegBus-2:0], fits};
            cnt_p0 <= cnt_p0 + 5'd1;
            if (cnt_p0 == 5'd31) state_p0 <= DIV_DONE;
          end
        end
        DIV_DONE: state_p0 <= DIV_IDLE;
        default:  state_p0 <= DIV_IDLE;
      endcase
    end
  end
endmodule
`endif

// File: rtl/ex_stage.sv
// RV32 execute stage: combinational ALU and multiplier plus the result mux.
// Define RV32M_EN to implement MUL*/DIV*/REM* (the divider is ex_div);
// without it those opcodes behave as unknown and stallreq_o is always 0.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            aluop_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegBus-1:0]     immt_i,
  input  logic [RegBus-1:0]     pc_store_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  ignore_i,
  input  logic                  flush_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallreq_o
);
  logic signed [RegBus-1:0] op1_s;
  logic signed [RegBus-1:0] op2_s;
  logic [4:0]               shamt;
  logic [RegBus-1:0]        alu_res;
  logic                     alu_vld;
  logic                     stall;

  assign op1_s = reg1_i;
  assign op2_s = reg2_i;
  assign shamt = reg2_i[4:0];

`ifdef RV32M_EN
  logic                       mul_a_signed;
  logic                       mul_b_signed;
  logic signed [RegBus:0]     mul_a;
  logic signed [RegBus:0]     mul_b;
  logic signed [2*RegBus+1:0] mul_prod;
  logic [1:0]                 unused_prod_hi;
  logic                       div_op;
  logic                       div_signed;
  logic                       div_busy;
  logic                       div_ready;
  logic [RegBus-1:0]          div_quo;
  logic [RegBus-1:0]          div_remd;

  // One 33x33 signed multiplier covers all four MUL variants by choosing how
  // each operand is extended.
  assign mul_a_signed   = (aluop_i == EXE_MULH_OP) || (aluop_i == EXE_MULHSU_OP);
  assign mul_b_signed   = (aluop_i == EXE_MULH_OP);
  assign mul_a          = {mul_a_signed & reg1_i[RegBus-1], reg1_i};
  assign mul_b          = {mul_b_signed & reg2_i[RegBus-1], reg2_i};
  assign mul_prod       = mul_a * mul_b;
  assign unused_prod_hi = mul_prod[2*RegBus+1:2*RegBus];

  assign div_op     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP) ||
                      (aluop_i == EXE_REM_OP) || (aluop_i == EXE_REMU_OP);
  assign div_signed = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_REM_OP);

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op & ~ignore_i),
    .is_signed (div_signed),
    .annul     (flush_i),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .busy      (div_busy),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_remd)
  );

  assign stall = div_busy & ~ignore_i;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign stall      = 1'b0;
`endif

  // Opcode decode and result selection; alu_vld drops for unknown opcodes
  always_comb begin
    alu_res = ZeroWord;
    alu_vld = 1'b1;
    case (aluop_i)
      EXE_ADD_OP:   alu_res = reg1_i + reg2_i;
      EXE_SUB_OP:   alu_res = reg1_i - reg2_i;
      EXE_AND_OP:   alu_res = reg1_i & reg2_i;
      EXE_OR_OP:    alu_res = reg1_i | reg2_i;
      EXE_XOR_OP:   alu_res = reg1_i ^ reg2_i;
      EXE_SLL_OP:   alu_res = reg1_i << shamt;
      EXE_SRL_OP:   alu_res = reg1_i >> shamt;
      EXE_SRA_OP:   alu_res = op1_s >>> shamt;
      EXE_SLT_OP:   alu_res = {{(RegBus-1){1'b0}}, (op1_s < op2_s)};
      EXE_SLTU_OP:  alu_res = {{(RegBus-1){1'b0}}, (reg1_i < reg2_i)};
      // immt_i already carries the upper-immediate in place
      EXE_LUI_OP:   alu_res = immt_i;
      EXE_AUIPC_OP: alu_res = pc_store_i + immt_i;
      EXE_JAL_OP,
      EXE_JALR_OP:  alu_res = pc_store_i + 32'd4;
`ifdef RV32M_EN
      EXE_MUL_OP:   alu_res = mul_prod[RegBus-1:0];
      EXE_MULH_OP,
      EXE_MULHSU_OP,
      EXE_MULHU_OP: alu_res = mul_prod[2*RegBus-1:RegBus];
      EXE_DIV_OP,
      EXE_DIVU_OP:  alu_res = div_ready ? div_quo : ZeroWord;
      EXE_REM_OP,
      EXE_REMU_OP:  alu_res = div_ready ? div_remd : ZeroWord;
`endif
      default:      alu_vld = 1'b0;
    endcase
  end

  // Output gating: a write is only offered for a valid, settled, unflushed op
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = ZeroWord;
    stallreq_o = 1'b0;
    if (rst != RstEnable) begin
      wd_o = wd_i;
      if (!ignore_i) begin
        wdata_o    = alu_vld ? alu_res : ZeroWord;
        wreg_o     = wreg_i & alu_vld & ~stall & ~flush_i;
        stallreq_o = stall & ~flush_i;
      end
    end
  end
endmodule
